pma_region_checker: RTL and testbench
=====================================

PMA_REGION_CHECKER -- requirements
Module: pma_region_checker

Interface
REQ-001 SHALL have parameter NrRules, default 16, number of programmable regions (1..16).
REQ-002 SHALL have parameter AddrWidth, default 64, address/base/length width (32..64).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cfg_we_i  input  1  region-table write strobe.
REQ-006 SHALL have port cfg_idx_i  input  $clog2(NrRules) (min 1)  region index to write.
REQ-007 SHALL have port cfg_base_i  input  AddrWidth  region base address.
REQ-008 SHALL have port cfg_len_i  input  AddrWidth  region length in bytes.
REQ-009 SHALL have port cfg_attr_i  input  4  {enable, exec, cache, nonidem}, bit 3 = enable.
REQ-010 SHALL have port req_valid_i / req_ready_o  input / output  1 each  lookup request handshake.
REQ-011 SHALL have port req_addr_i  input  AddrWidth  lookup address.
REQ-012 SHALL have port rsp_valid_o / rsp_ready_i  output / input  1 each  lookup response handshake.
REQ-013 SHALL have port rsp_hit_o  output  1  address inside at least one enabled region.
REQ-014 SHALL have port rsp_idx_o  output  $clog2(NrRules) (min 1)  lowest-index matching region.
REQ-015 SHALL have ports rsp_exec_o, rsp_cache_o, rsp_nonidem_o  output  1 each  attributes of matched region.

Function
REQ-016 SHALL match region k iff enabled, len != 0, addr >= base, and zero-extended addr < base + len computed at AddrWidth+1 bits (no wrap).
REQ-017 SHALL resolve multiple matches to the lowest index; rsp_idx_o and attributes come from that region only.
REQ-018 SHALL on miss drive rsp_hit_o=0, rsp_idx_o=0, rsp_cache_o=0, rsp_nonidem_o=0.
REQ-019 SHALL on miss drive rsp_exec_o=1 if no region has enable=1 and exec=1, else 0.
REQ-020 SHALL accept a request when req_valid_i && req_ready_o; the response is registered with a latency of exactly 1 cycle.
REQ-021 SHALL drive req_ready_o = !rsp_valid_o || rsp_ready_i (single output stage, back-to-back throughput of 1/cycle).
REQ-022 SHALL hold rsp_valid_o and all rsp_* outputs stable while rsp_valid_o && !rsp_ready_i.
REQ-023 SHALL clear rsp_valid_o after the handshake when no new request is accepted in the same cycle.
REQ-024 SHALL commit cfg_we_i writes at the clock edge; a lookup accepted in the same cycle uses the pre-write table.
REQ-025 SHALL ignore writes with cfg_idx_i >= NrRules.
REQ-026 SHALL not alter an already-registered response when the table is rewritten.

Reset
REQ-027 SHALL on rst_ni=0 at a clock edge clear all regions (enable=0, base=0, len=0, attrs=0).
REQ-028 SHALL on reset drive rsp_valid_o=0, rsp_hit_o=0, rsp_idx_o=0, rsp_exec_o=0, rsp_cache_o=0, rsp_nonidem_o=0; req_ready_o=1 after reset.
REQ-029 SHALL drop an in-flight response on reset mid-operation; no response is delivered for it.

Configuration
REQ-030 SHALL with macro PMA_REGION_LOCK_EN defined add input cfg_lock_i (1 bit); a write with cfg_lock_i=1 sets the region's lock bit, and later writes to a locked region are ignored until reset.
REQ-031 SHALL without PMA_REGION_LOCK_EN have no cfg_lock_i port, no lock state, and all in-range writes take effect.

Verification
REQ-032 SHALL cover: region 0 = base 0x8000_0000, len 0x1000, attr 0xE; lookup 0x8000_0FFF -> next cycle hit=1, idx=0, exec=1, cache=1, nonidem=0; lookup 0x8000_1000 -> hit=0, exec=0.
REQ-033 SHALL cover: region 2 base 0x0, len 0x1_0000 attr 0x9 and region 5 base 0x8000 len 0x100 attr 0xE; lookup 0x8010 -> hit=1, idx=2, nonidem=1, exec=0.
REQ-034 SHALL cover: region 0 base 0xFFFF_FFFF_FFFF_F000, len 0x1000 (AddrWidth=64); lookup 0xFFFF_FFFF_FFFF_FFFF -> hit=1; lookup 0x0 -> hit=0.
REQ-035 SHALL cover: 4 back-to-back requests with rsp_ready_i=0 for 3 cycles -> req_ready_o=0, first response held stable, all 4 responses delivered in order with no loss.
REQ-036 SHALL cover: empty table, lookup 0x1234 -> hit=0, exec=1; write region 1 same cycle as lookup -> response reflects old table.
REQ-037 SHALL cover: with PMA_REGION_LOCK_EN, write region 3 with cfg_lock_i=1, then rewrite base -> old base still matches; assert rst_ni=0 -> region cleared, unlocked.

Source files
------------

// File: rtl/pma_region_checker.sv
// rtl/pma_region_checker.sv - programmable PMA region table with a registered lowest-index lookup
// Optional: define PMA_REGION_LOCK_EN to add cfg_lock_i and per-region write locks held until reset.
module pma_region_checker #(
    parameter int NrRules   = 16,
    parameter int AddrWidth = 64,
    localparam int IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [IdxWidth-1:0]  cfg_idx_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_len_i,
    input  logic [3:0]           cfg_attr_i,
`ifdef PMA_REGION_LOCK_EN
    input  logic                 cfg_lock_i,
`endif
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic [IdxWidth-1:0]  rsp_idx_o,
    output logic                 rsp_exec_o,
    output logic                 rsp_cache_o,
    output logic                 rsp_nonidem_o
);

    logic [AddrWidth-1:0] baseQ [NrRules];
    logic [AddrWidth-1:0] lenQ  [NrRules];
    logic [3:0]           attrQ [NrRules];

    logic [NrRules-1:0] regionMatch;
    logic [NrRules-1:0] execEnabled;
    logic [NrRules-1:0] writeSel;

    logic                lkHit;
    logic [IdxWidth-1:0] lkIdx;
    logic                lkExec;
    logic                lkCache;
    logic                lkNonidem;
    logic                anyExec;
    logic                reqFire;

    // Limit is formed one bit wider so a region ending at the top of the address space cannot wrap.
    for (genvar k = 0; k < NrRules; k++) begin : genMatch
        logic [AddrWidth:0] limit;
        assign limit          = {1'b0, baseQ[k]} + {1'b0, lenQ[k]};
        assign regionMatch[k] = attrQ[k][3] && (lenQ[k] != '0)
                                && (req_addr_i >= baseQ[k])
                                && ({1'b0, req_addr_i} < limit);
        assign execEnabled[k] = attrQ[k][3] & attrQ[k][2];
    end

    assign anyExec = |execEnabled;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        lkHit     = 1'b0;
        lkIdx     = '0;
        lkExec    = 1'b0;
        lkCache   = 1'b0;
        lkNonidem = 1'b0;
        for (int k = NrRules - 1; k >= 0; k--) begin
            if (regionMatch[k]) begin
                lkHit     = 1'b1;
                lkIdx     = IdxWidth'(k);
                lkExec    = attrQ[k][2];
                lkCache   = attrQ[k][1];
                lkNonidem = attrQ[k][0];
            end
        end
    end

`ifdef PMA_REGION_LOCK_EN
    logic [NrRules-1:0] lockQ;
`endif

    // Index decode by comparison: indices at or above NrRules select nothing.
    always_comb begin
        writeSel = '0;
        for (int k = 0; k < NrRules; k++) begin
`ifdef PMA_REGION_LOCK_EN
            writeSel[k] = cfg_we_i && (cfg_idx_i == IdxWidth'(k)) && !lockQ[k];
`else
            writeSel[k] = cfg_we_i && (cfg_idx_i == IdxWidth'(k));
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NrRules; k++) begin
            if (!rst_ni) begin
                baseQ[k] <= '0;
                lenQ[k]  <= '0;
                attrQ[k] <= '0;
            end else if (writeSel[k]) begin
                baseQ[k] <= cfg_base_i;
                lenQ[k]  <= cfg_len_i;
                attrQ[k] <= cfg_attr_i;
            end
        end
    end

`ifdef PMA_REGION_LOCK_EN
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NrRules; k++) begin
            if (!rst_ni) begin
                lockQ[k] <= 1'b0;
            end else if (writeSel[k]) begin
                lockQ[k] <= cfg_lock_i;
            end
        end
    end
`endif

    assign req_ready_o = !rsp_valid_o || rsp_ready_i;
    assign reqFire     = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_o   <= 1'b0;
            rsp_hit_o     <= 1'b0;
            rsp_idx_o     <= '0;
            rsp_exec_o    <= 1'b0;
            rsp_cache_o   <= 1'b0;
            rsp_nonidem_o <= 1'b0;
        end else if (reqFire) begin
            rsp_valid_o   <= 1'b1;
            rsp_hit_o     <= lkHit;
            rsp_idx_o     <= lkIdx;
            rsp_exec_o    <= lkHit ? lkExec : !anyExec;
            rsp_cache_o   <= lkCache;
            rsp_nonidem_o <= lkNonidem;
        end else if (rsp_ready_i) begin
            rsp_valid_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pma_region_checker.sv
// tb/tb_pma_region_checker.sv - directed bench with a cycle model for pma_region_checker
// Lock scenarios are included when PMA_REGION_LOCK_EN is defined.
module tb_pma_region_checker;
    localparam int NrRules   = 6;
    localparam int AddrWidth = 64;
    localparam int IdxWidth  = 3;

    logic                 clk;
    logic                 rst_ni;
    logic                 cfg_we_i;
    logic [IdxWidth-1:0]  cfg_idx_i;
    logic [AddrWidth-1:0] cfg_base_i;
    logic [AddrWidth-1:0] cfg_len_i;
    logic [3:0]           cfg_attr_i;
`ifdef PMA_REGION_LOCK_EN
    logic                 cfg_lock_i;
`endif
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_addr_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic                 rsp_hit_o;
    logic [IdxWidth-1:0]  rsp_idx_o;
    logic                 rsp_exec_o;
    logic                 rsp_cache_o;
    logic                 rsp_nonidem_o;

    pma_region_checker #(.NrRules(NrRules), .AddrWidth(AddrWidth)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_base_i(cfg_base_i),
        .cfg_len_i(cfg_len_i), .cfg_attr_i(cfg_attr_i),
`ifdef PMA_REGION_LOCK_EN
        .cfg_lock_i(cfg_lock_i),
`endif
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
        .rsp_idx_o(rsp_idx_o), .rsp_exec_o(rsp_exec_o), .rsp_cache_o(rsp_cache_o),
        .rsp_nonidem_o(rsp_nonidem_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVec  = 0;
    int nFail = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic       exec;
        logic       cache;
        logic       nonidem;
    } rsp_t;

    // Reference table and response register, advanced once per clock from the inputs that edge will see.
    logic [63:0] mBase [NrRules];
    logic [63:0] mLen  [NrRules];
    logic [3:0]  mAttr [NrRules];
    logic        mLock [NrRules];
    logic        mKnown = 1'b0;
    logic        mValid;
    logic        mZero;
    rsp_t        mRsp;
    logic        mReady;
    logic        logHit [$];
    int          logIdx [$];

    assign mReady = !mValid || rsp_ready_i;

    function automatic rsp_t modelLookup(logic [63:0] a);
        rsp_t r;
        logic anyX;
        r    = '0;
        anyX = 1'b0;
        for (int k = 0; k < NrRules; k++)
            if (mAttr[k][3] && mAttr[k][2]) anyX = 1'b1;
        for (int k = 0; k < NrRules; k++) begin
            if (!r.hit && mAttr[k][3] && a >= mBase[k] && (a - mBase[k]) < mLen[k]) begin
                r.hit     = 1'b1;
                r.idx     = 3'(k);
                r.exec    = mAttr[k][2];
                r.cache   = mAttr[k][1];
                r.nonidem = mAttr[k][0];
            end
        end
        if (!r.hit) r.exec = !anyX;
        return r;
    endfunction

    always @(negedge clk) begin
        if (mKnown) begin
            check("cmp.req_ready", 64'(req_ready_o), 64'(mReady));
            check("cmp.rsp_valid", 64'(rsp_valid_o), 64'(mValid));
            if (mValid || mZero) begin
                check("cmp.hit",     64'(rsp_hit_o),     64'(mRsp.hit));
                check("cmp.idx",     64'(rsp_idx_o),     64'(mRsp.idx));
                check("cmp.exec",    64'(rsp_exec_o),    64'(mRsp.exec));
                check("cmp.cache",   64'(rsp_cache_o),   64'(mRsp.cache));
                check("cmp.nonidem", 64'(rsp_nonidem_o), 64'(mRsp.nonidem));
            end
            if (rsp_valid_o && rsp_ready_i) begin
                logHit.push_back(rsp_hit_o);
                logIdx.push_back(int'(rsp_idx_o));
            end
        end
        if (!rst_ni) begin
            mKnown <= 1'b1;
            mValid <= 1'b0;
            mZero  <= 1'b1;
            mRsp   <= '0;
            for (int k = 0; k < NrRules; k++) begin
                mBase[k] <= '0;
                mLen[k]  <= '0;
                mAttr[k] <= '0;
                mLock[k] <= 1'b0;
            end
        end else if (mKnown) begin
            if (req_valid_i && mReady) begin
                mValid <= 1'b1;
                mZero  <= 1'b0;
                mRsp   <= modelLookup(req_addr_i);
            end else if (rsp_ready_i) begin
                mValid <= 1'b0;
            end
            if (cfg_we_i && int'(cfg_idx_i) < NrRules) begin
                if (!mLock[cfg_idx_i]) begin
                    mBase[cfg_idx_i] <= cfg_base_i;
                    mLen[cfg_idx_i]  <= cfg_len_i;
                    mAttr[cfg_idx_i] <= cfg_attr_i;
`ifdef PMA_REGION_LOCK_EN
                    mLock[cfg_idx_i] <= cfg_lock_i;
`endif
                end
            end
        end
    end

    task automatic cfgSet(int idx, logic [63:0] b, logic [63:0] l, logic [3:0] at, logic lk);
        cfg_we_i   = 1'b1;
        cfg_idx_i  = 3'(idx);
        cfg_base_i = b;
        cfg_len_i  = l;
        cfg_attr_i = at;
`ifdef PMA_REGION_LOCK_EN
        cfg_lock_i = lk;
`else
        if (lk) $display("note: lock request ignored in this build");
`endif
    endtask

    task automatic cfgWrite(int idx, logic [63:0] b, logic [63:0] l, logic [3:0] at, logic lk);
        cfgSet(idx, b, l, at, lk);
        @(posedge clk); #1;
        cfg_we_i = 1'b0;
    endtask

    task automatic checkRsp(string n, logic h, int i, logic x, logic c, logic nd);
        check({n, ".valid"},   64'(rsp_valid_o),   64'(1));
        check({n, ".hit"},     64'(rsp_hit_o),     64'(h));
        check({n, ".idx"},     64'(rsp_idx_o),     64'(i));
        check({n, ".exec"},    64'(rsp_exec_o),    64'(x));
        check({n, ".cache"},   64'(rsp_cache_o),   64'(c));
        check({n, ".nonidem"}, 64'(rsp_nonidem_o), 64'(nd));
    endtask

    task automatic lookupExpect(string n, logic [63:0] a, logic h, int i, logic x, logic c, logic nd);
        req_addr_i  = a;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        checkRsp(n, h, i, x, c, nd);
        @(posedge clk); #1;
    endtask

    logic [63:0] bpAddr [4];
    logic        bpHit  [4];
    int          bpIdx  [4];

    initial begin
        rst_ni = 1'b0; rsp_ready_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0;
        cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_base_i = '0; cfg_len_i = '0; cfg_attr_i = '0;
`ifdef PMA_REGION_LOCK_EN
        cfg_lock_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("rst.rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst.req_ready", 64'(req_ready_o), 64'(1));
        check("rst.hit",  64'(rsp_hit_o),  64'(0));
        check("rst.idx",  64'(rsp_idx_o),  64'(0));
        check("rst.exec", 64'(rsp_exec_o), 64'(0));
        check("rst.cache_nonidem", 64'({rsp_cache_o, rsp_nonidem_o}), 64'(0));
        @(posedge clk); #1;

        lookupExpect("empty", 64'h1234, 0, 0, 1, 0, 0);

        // Write lands on the same edge that accepts the lookup: old table must answer.
        cfgSet(1, 64'h1000, 64'h1000, 4'h8, 0);
        req_addr_i  = 64'h1234;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        cfg_we_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk);
        checkRsp("samecyc", 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        lookupExpect("r1hit", 64'h1234, 1, 1, 0, 0, 0);

        cfgWrite(0, 64'h8000_0000, 64'h1000, 4'hE, 0);
        lookupExpect("r0last", 64'h8000_0FFF, 1, 0, 1, 1, 0);
        lookupExpect("r0end",  64'h8000_1000, 0, 0, 0, 0, 0);
        lookupExpect("r0base", 64'h8000_0000, 1, 0, 1, 1, 0);

        cfgWrite(2, 64'h0, 64'h1_0000, 4'h9, 0);
        cfgWrite(5, 64'h8000, 64'h100, 4'hE, 0);
        lookupExpect("overlap", 64'h8010, 1, 2, 0, 0, 1);
        lookupExpect("lowidx",  64'h1234, 1, 1, 0, 0, 0);

        cfgWrite(6, 64'h4000_0000, 64'h100, 4'hE, 0);
        lookupExpect("oorwrite", 64'h4000_0000, 0, 0, 0, 0, 0);
        cfgWrite(4, 64'h5000_0000, 64'h0, 4'hF, 0);
        lookupExpect("zerolen", 64'h5000_0000, 0, 0, 0, 0, 0);

        cfgWrite(2, 64'h0, 64'h1_0000, 4'h0, 0);
        cfgWrite(0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 4'hC, 0);
        lookupExpect("topmax",  64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 0, 0);
        lookupExpect("nowrap",  64'h0, 0, 0, 0, 0, 0);
        lookupExpect("topbelow", 64'hFFFF_FFFF_FFFF_EFFF, 0, 0, 0, 0, 0);

        // Four back-to-back lookups with the response side stalled for three edges.
        bpAddr = '{64'h8010, 64'h1800, 64'hFFFF_FFFF_FFFF_F800, 64'h9000};
        bpHit  = '{1'b1, 1'b1, 1'b1, 1'b0};
        bpIdx  = '{5, 1, 0, 0};
        logHit.delete();
        logIdx.delete();
        rsp_ready_i = 1'b0;
        req_addr_i  = bpAddr[0];
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_addr_i = bpAddr[1];
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp.req_ready", 64'(req_ready_o), 64'(0));
            checkRsp("bp.held", 1, 5, 1, 1, 0);
            @(posedge clk); #1;
        end
        rsp_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            req_addr_i = bpAddr[i];
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bp.count", 64'(logHit.size()), 64'(4));
        for (int i = 0; i < 4 && i < logHit.size(); i++) begin
            check("bp.order.hit", 64'(logHit[i]), 64'(bpHit[i]));
            check("bp.order.idx", 64'(logIdx[i]), 64'(bpIdx[i]));
        end

        // Table rewrite while a response is parked must not disturb it.
        rsp_ready_i = 1'b0;
        req_addr_i  = 64'h8010;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        cfgWrite(5, 64'h8000, 64'h100, 4'h0, 0);
        @(negedge clk);
        checkRsp("parked", 1, 5, 1, 1, 0);
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        lookupExpect("r5off", 64'h8010, 0, 0, 0, 0, 0);

`ifdef PMA_REGION_LOCK_EN
        cfgWrite(3, 64'h2000_0000, 64'h100, 4'h8, 1);
        cfgWrite(3, 64'h3000_0000, 64'h100, 4'h8, 0);
        lookupExpect("lock.old", 64'h2000_0010, 1, 3, 0, 0, 0);
        lookupExpect("lock.new", 64'h3000_0010, 0, 0, 0, 0, 0);
`endif

        // Reset with a response in flight: it is dropped and the table is cleared.
        rsp_ready_i = 1'b0;
        req_addr_i  = 64'h1800;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        rst_ni      = 1'b0;
        @(posedge clk); #1;
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        check("midrst.valid", 64'(rsp_valid_o), 64'(0));
        check("midrst.hit",   64'(rsp_hit_o),   64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst.nodeliver", 64'(rsp_valid_o), 64'(0));
        @(posedge clk); #1;
        lookupExpect("midrst.cleared", 64'h1800, 0, 0, 1, 0, 0);

`ifdef PMA_REGION_LOCK_EN
        lookupExpect("unlock.cleared", 64'h2000_0010, 0, 0, 1, 0, 0);
        cfgWrite(3, 64'h3000_0000, 64'h100, 4'h8, 0);
        lookupExpect("unlock.rewrite", 64'h3000_0010, 1, 3, 0, 0, 0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
